// File: rtl/uart_tx_if.sv
// Read-side link between the transmit FIFO and the UART transmitter.
// Handshake: fifo_rd is a one-cycle pop strobe, legal only while fifo_empty=0; fifo_data holds the popped byte from the following cycle.
interface uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter draining a byte FIFO, with back-to-back frames while data remains.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int COUNT_BITS   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  uart_tx_if.master   fifo,
  output logic        tx,
  output logic        busy,
  output logic [2:0]  state_dbg
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_PARITY
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_STOP
  } state_e;
`endif

  localparam logic [COUNT_BITS-1:0] CNT_LAST = COUNT_BITS'(CLKS_PER_BIT - 1);

  state_e                state_q, state_d;
  logic [COUNT_BITS-1:0] cnt_q, cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  rd_c;
  logic                  bit_end;
  logic                  pop_ok;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == CNT_LAST);
  assign pop_ok  = enable & ~fifo.fifo_empty;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    rd_c      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop_ok) begin
          rd_c    = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        shift_d  = fifo.fifo_data;
        cnt_d    = '0;
        tx_d     = 1'b0;
        state_d  = S_START;
`ifdef UART_TX_PARITY_EN
        parity_d = ^fifo.fifo_data;
`endif
      end
      S_START: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
          state_d   = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            // shift_q[1] is the bit that lands in position 0 after this shift
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Pop in the last stop cycle so the next start bit follows without an idle bit
          if (pop_ok) begin
            rd_c    = 1'b1;
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // State is forced to IDLE during reset, so the strobe is also gated by rst to keep it low there
  assign fifo.fifo_rd = rd_c & rst;
  assign busy         = (state_q != S_IDLE) | fifo.fifo_rd;
  assign tx           = tx_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx (CLKS_PER_BIT=4) against a frame-timeline reference model.
// Also pins the model with hand-computed waveforms for the directed scenarios.
module tb_uart_tx;
  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int L = 2 + NB * C;   // pop cycle + load cycle + bit times

  logic       clk;
  logic       rst;
  logic       enable;
  logic       tx;
  logic       busy;
  logic [2:0] state_dbg;

  uart_tx_if ifc ();

  uart_tx #(.CLKS_PER_BIT(C), .COUNT_BITS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .fifo      (ifc),
    .tx        (tx),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- bench state ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] fq[$];      // FIFO contents as seen by the DUT
  logic [7:0] exp_q[$];   // scoreboard: bytes the model expects to be sent
  bit tx_log[$];
  bit rd_log[$];
  bit busy_log[$];
  bit rst_drv;
  bit en_drv;
  int pos;                // -1 idle, else cycle offset since the pop
  logic [7:0] cur_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
    if (j == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b);
    exp_q.push_back(b);
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the FIFO.
  task automatic tick();
    bit can_pop, e_tx, e_rd, e_busy, popped;
    @(negedge clk);
    rst            = rst_drv;
    enable         = en_drv;
    ifc.fifo_empty = (fq.size() == 0);
    #1;
    if (!rst) begin
      pos     = -1;
      can_pop = 1'b0;
    end else begin
      can_pop = (pos == -1 || pos == L - 1) && enable && !ifc.fifo_empty;
    end
    e_rd   = can_pop;
    e_busy = (pos >= 1) || can_pop;
    e_tx   = (pos >= 2) ? frame_bit(cur_b, (pos - 2) / C) : 1'b1;
    chk("fifo_rd", 32'(ifc.fifo_rd), 32'(e_rd));
    chk("tx", 32'(tx), 32'(e_tx));
    chk("busy", 32'(busy), 32'(e_busy));
    tx_log.push_back(tx);
    rd_log.push_back(ifc.fifo_rd);
    busy_log.push_back(busy);
    if (can_pop) begin
      cur_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      pos   = 1;
    end else if (pos == -1 || pos == L - 1) begin
      pos = -1;
    end else begin
      pos++;
    end
    popped = ifc.fifo_rd;
    @(posedge clk);
    #1;
    if (popped && fq.size() > 0) ifc.fifo_data = fq.pop_front();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic int pops_from(input int s);
    int n = 0;
    for (int i = s; i < rd_log.size(); i++) n += int'(rd_log[i]);
    return n;
  endfunction

  function automatic int busy_from(input int s);
    int n = 0;
    for (int i = s; i < busy_log.size(); i++) n += int'(busy_log[i]);
    return n;
  endfunction

  function automatic int zeros_from(input int s);
    int n = 0;
    for (int i = s; i < tx_log.size(); i++) n += int'(!tx_log[i]);
    return n;
  endfunction

  function automatic int find_pop(input int s);
    for (int i = s; i < rd_log.size(); i++) if (rd_log[i]) return i;
    return -1;
  endfunction

  function automatic bit tx_at(input int i);
    if (i < 0 || i >= tx_log.size()) return 1'bx;
    return tx_log[i];
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    int s, p, p2;
    logic [10:0] pat;
    rst = 1'b0; enable = 1'b0;
    ifc.fifo_empty = 1'b1; ifc.fifo_data = 8'h00;
    pos = -1; cur_b = 8'h00;
    rst_drv = 1'b0; en_drv = 1'b1;

    // Reset held with a non-empty FIFO: no pop until release, then one at once
    push_byte(8'h3C);
    ticks(5);
    chk("reset_no_pop", 32'(pops_from(0)), 32'd0);
    rst_drv = 1'b1;
    s = rd_log.size();
    tick();
    chk("first_idle_pop", 32'(rd_log[s]), 32'd1);
    ticks(L + 10);

    // Single byte 0xA5: literal bit pattern and busy length
    s = rd_log.size();
    push_byte(8'hA5);
    ticks(L + 15);
    chk("a5_pops", 32'(pops_from(s)), 32'd1);
    p = find_pop(s);
`ifdef UART_TX_PARITY_EN
    pat = 11'b1_0_1010_0101_0;   // stop, parity, data MSB..LSB, start
    chk("a5_busy_len", 32'(busy_from(s)), 32'd46);
`else
    pat = 11'b1_1_1010_0101_0;   // bit 10 unused
    chk("a5_busy_len", 32'(busy_from(s)), 32'd42);
`endif
    for (int b = 0; b < NB; b++)
      chk($sformatf("a5_bit%0d", b), 32'(tx_at(p + 2 + b * C + C / 2)), 32'(pat[b]));

    // 0x00 then 0xFF back to back
    s = rd_log.size();
    push_byte(8'h00);
    push_byte(8'hFF);
    ticks(2 * L + 15);
    chk("b2b_pops", 32'(pops_from(s)), 32'd2);
    p  = find_pop(s);
    p2 = find_pop(p + 1);
`ifdef UART_TX_PARITY_EN
    chk("b2b_spacing", 32'(p2 - p), 32'd45);
`else
    chk("b2b_spacing", 32'(p2 - p), 32'd41);
`endif
    chk("b2b_stop_at_pop", 32'(tx_at(p2)), 32'd1);
    chk("b2b_next_start", 32'(tx_at(p2 + 2)), 32'd0);

    // enable low with data waiting
    en_drv = 1'b0;
    s = rd_log.size();
    push_byte(8'h55);
    ticks(100);
    chk("dis_no_pop", 32'(pops_from(s)), 32'd0);
    chk("dis_tx_high", 32'(zeros_from(s)), 32'd0);
    // enable, then drop it 10 cycles into the frame with more data waiting
    en_drv = 1'b1;
    s = rd_log.size();
    tick();
    push_byte(8'h66);
    ticks(9);
    en_drv = 1'b0;
    ticks(L + 20);
    chk("dis_mid_one_pop", 32'(pops_from(s)), 32'd1);
    en_drv = 1'b1;
    ticks(L + 10);

    // Asynchronous reset in the middle of the data bits
    push_byte(8'h00);
    for (int i = 0; i < 40 && pos != 2 + 3 * C; i++) tick();
    chk("pre_rst_pos", 32'(pos), 32'(2 + 3 * C));
    chk("pre_rst_tx", 32'(tx), 32'd0);
    #2;
    rst = 1'b0; rst_drv = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    ticks(3);
    rst_drv = 1'b1;
    s = rd_log.size();
    push_byte(8'h5A);
    ticks(L + 10);
    chk("post_rst_pops", 32'(pops_from(s)), 32'd1);
    p = find_pop(s);
    chk("post_rst_start", 32'(tx_at(p + 2)), 32'd0);

`ifdef UART_TX_PARITY_EN
    s = rd_log.size();
    push_byte(8'h07);
    ticks(L + 10);
    p = find_pop(s);
    chk("par07_bit", 32'(tx_at(p + 2 + 9 * C + C / 2)), 32'd1);
    chk("par07_stop", 32'(tx_at(p + 2 + 10 * C + C / 2)), 32'd1);
    s = rd_log.size();
    push_byte(8'h03);
    ticks(L + 10);
    p = find_pop(s);
    chk("par03_bit", 32'(tx_at(p + 2 + 9 * C + C / 2)), 32'd0);
`endif

    // Random traffic with enable toggling
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 14) == 0) push_byte(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 59) == 0) en_drv = ~en_drv;
      tick();
    end
    en_drv = 1'b1;
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || pos != -1); i++) tick();
    chk("drain_fifo", 32'(fq.size()), 32'd0);
    chk("drain_model", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
